// File: rtl/bp_table_scheduler.sv
// bp_table_scheduler
//
// Sole master of the branch-predictor storage: a 16x4 branch history table (BHT)
// and a 128x2 pattern history table (PHT) of 2-bit saturating counters. Both are
// single-port SRAMs with synchronous read (data valid the cycle after the address).
//
// After reset both tables are swept to known values. The block then arbitrates
// between fetch-side lookups and commit-side updates. Updates are buffered in a
// small FIFO so commit can keep reporting while a lookup is in progress.
//
// Ports:
//   clk, resetn                  clock (rising edge), async active-low reset
//   lookup_valid/pc/ready        fetch prediction request handshake
//   pred_valid, pred_taken       one-cycle prediction result
//   upd_valid/pc/taken/ready     commit outcome push into the update FIFO
//   init_done                    table sweep complete, sticky until reset
//   bht_addr/we/wdata/rdata      BHT SRAM port
//   pht_addr/we/wdata/rdata      PHT SRAM port
//
// Hash: BHT index = XOR of the eight PC nibbles, PHT index = {pc[2:0], history}.

module bp_table_scheduler #(
    parameter int unsigned QDEPTH   = 4,
    parameter logic [1:0]  PHT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        lookup_ready,
    output logic        pred_valid,
    output logic        pred_taken,

    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        upd_ready,

    output logic        init_done,

    output logic [3:0]  bht_addr,
    output logic        bht_we,
    output logic [3:0]  bht_wdata,
    input  logic [3:0]  bht_rdata,

    output logic [6:0]  pht_addr,
    output logic        pht_we,
    output logic [1:0]  pht_wdata,
    input  logic [1:0]  pht_rdata
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StLkBht,
        StLkPht,
        StLkRes,
        StUpBht,
        StUpPht,
        StUpWr
    } state_e;

    state_e            state_q;
    logic [6:0]        sweep_cnt_q;
    // Low while resetn is held and for the first edge after release; keeps all
    // write enables and upd_ready at zero during reset without a combinational
    // path from resetn to the outputs.
    logic              live_q;
    logic [31:0]       pc_q;
    logic              taken_q;
    logic [3:0]        bhr_q;

    // Update FIFO
    logic [31:0]       fifo_pc    [QDEPTH];
    logic              fifo_taken [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              lk_go;
    logic [1:0]        cnt_next;

    function automatic logic [3:0] pc_hash(input logic [31:0] pc);
        logic [3:0] h;
        h = 4'h0;
        for (int i = 0; i < 8; i++) begin
            h = h ^ pc[i*4 +: 4];
        end
        return h;
    endfunction

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign upd_ready  = live_q && !fifo_full;
    assign push       = upd_valid && upd_ready;

    assign lookup_ready = (state_q == StIdle) && init_done && !fifo_full;

    // A full FIFO beats a pending lookup so commit never stalls indefinitely;
    // otherwise lookups have priority over draining the FIFO.
    assign pop   = (state_q == StIdle) && init_done &&
                   (fifo_full || (!lookup_valid && !fifo_empty));
    assign lk_go = lookup_valid && lookup_ready;

    // ------------------------------------------------------------------
    // Update FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]    <= upd_pc;
            fifo_taken[wr_ptr_q] <= upd_taken;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered result outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StInit;
            sweep_cnt_q <= '0;
            live_q      <= 1'b0;
            init_done   <= 1'b0;
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pc_q        <= '0;
            taken_q     <= 1'b0;
            bhr_q       <= '0;
        end else begin
            live_q     <= 1'b1;
            pred_valid <= 1'b0;
            unique case (state_q)
                StInit: begin
                    if (live_q) begin
                        sweep_cnt_q <= sweep_cnt_q + 7'd1;
                        if (sweep_cnt_q == 7'd127) begin
                            state_q   <= StIdle;
                            init_done <= 1'b1;
                        end
                    end
                end
                StIdle: begin
                    if (pop) begin
                        pc_q    <= fifo_pc[rd_ptr_q];
                        taken_q <= fifo_taken[rd_ptr_q];
                        state_q <= StUpBht;
                    end else if (lk_go) begin
                        pc_q    <= lookup_pc;
                        state_q <= StLkBht;
                    end
                end
                StLkBht: state_q <= StLkPht;
                StLkPht: begin
                    bhr_q   <= bht_rdata;
                    state_q <= StLkRes;
                end
                StLkRes: begin
                    pred_taken <= pht_rdata[1];
                    pred_valid <= 1'b1;
                    state_q    <= StIdle;
                end
                StUpBht: state_q <= StUpPht;
                StUpPht: begin
                    bhr_q   <= bht_rdata;
                    state_q <= StUpWr;
                end
                StUpWr:  state_q <= StIdle;
                default: state_q <= StInit;
            endcase
        end
    end

    // Saturating counter step for the update write.
    always_comb begin
        cnt_next = pht_rdata;
        if (taken_q) begin
            if (pht_rdata != 2'b11) begin
                cnt_next = pht_rdata + 2'b01;
            end
        end else begin
            if (pht_rdata != 2'b00) begin
                cnt_next = pht_rdata - 2'b01;
            end
        end
    end

    // ------------------------------------------------------------------
    // SRAM port drive. The PHT address in the *_PHT states must come straight
    // from bht_rdata so the counter read lands in the following state.
    // ------------------------------------------------------------------
    always_comb begin
        bht_addr  = 4'h0;
        bht_we    = 1'b0;
        bht_wdata = 4'h0;
        pht_addr  = 7'h0;
        pht_we    = 1'b0;
        pht_wdata = 2'b00;
        unique case (state_q)
            StInit: begin
                pht_we    = live_q;
                pht_addr  = sweep_cnt_q;
                pht_wdata = live_q ? PHT_INIT : 2'b00;
                bht_we    = live_q && (sweep_cnt_q < 7'd16);
                bht_addr  = sweep_cnt_q[3:0];
            end
            StLkBht, StUpBht: begin
                bht_addr = pc_hash(pc_q);
            end
            StLkPht, StUpPht: begin
                bht_addr = pc_hash(pc_q);
                pht_addr = {pc_q[2:0], bht_rdata};
            end
            StLkRes: begin
                pht_addr = {pc_q[2:0], bhr_q};
            end
            StUpWr: begin
                pht_we    = 1'b1;
                pht_addr  = {pc_q[2:0], bhr_q};
                pht_wdata = cnt_next;
                bht_we    = 1'b1;
                bht_addr  = pc_hash(pc_q);
                bht_wdata = {bhr_q[2:0], taken_q};
            end
            default: begin
                bht_addr = 4'h0;
            end
        endcase
    end

endmodule

// File: tb/tb_bp_table_scheduler.sv
// Bench for bp_table_scheduler: behavioural SRAMs, an abstract predictor model
// feeding an expectation queue, and a negedge monitor popping it.

module tb_bp_table_scheduler;

    logic        clk;
    logic        resetn;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        lookup_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_ready;
    logic        init_done;
    logic [3:0]  bht_addr;
    logic        bht_we;
    logic [3:0]  bht_wdata;
    logic [3:0]  bht_rdata;
    logic [6:0]  pht_addr;
    logic        pht_we;
    logic [1:0]  pht_wdata;
    logic [1:0]  pht_rdata;

    bp_table_scheduler #(
        .QDEPTH   (4),
        .PHT_INIT (2'b01)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .lookup_ready (lookup_ready),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_ready    (upd_ready),
        .init_done    (init_done),
        .bht_addr     (bht_addr),
        .bht_we       (bht_we),
        .bht_wdata    (bht_wdata),
        .bht_rdata    (bht_rdata),
        .pht_addr     (pht_addr),
        .pht_we       (pht_we),
        .pht_wdata    (pht_wdata),
        .pht_rdata    (pht_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read single-port SRAMs
    logic [3:0] bht_mem [16];
    logic [1:0] pht_mem [128];
    always @(posedge clk) begin
        if (bht_we) bht_mem[bht_addr] <= bht_wdata;
        bht_rdata <= bht_mem[bht_addr];
        if (pht_we) pht_mem[pht_addr] <= pht_wdata;
        pht_rdata <= pht_mem[pht_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference predictor and expectation queue
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       is_pred;
        logic       taken;
        logic [6:0] pa;
        logic [1:0] pd;
        logic [3:0] ba;
        logic [3:0] bd;
    } ev_t;

    ev_t        sb_q [$];
    logic [3:0] ref_bht [16];
    logic [1:0] ref_pht [128];

    function automatic logic [3:0] ref_hash(input logic [31:0] pc);
        return pc[3:0] ^ pc[7:4] ^ pc[11:8] ^ pc[15:12] ^
               pc[19:16] ^ pc[23:20] ^ pc[27:24] ^ pc[31:28];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) ref_bht[i] = 4'h0;
        for (int i = 0; i < 128; i++) ref_pht[i] = 2'b01;
    endfunction

    function automatic logic [6:0] model_lookup(input logic [31:0] pc);
        ev_t e;
        logic [6:0] idx;
        idx = {pc[2:0], ref_bht[ref_hash(pc)]};
        e = '0;
        e.is_pred = 1'b1;
        e.taken = ref_pht[idx][1];
        sb_q.push_back(e);
        return idx;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic tk);
        ev_t e;
        logic [3:0] h;
        logic [6:0] idx;
        int c;
        h = ref_hash(pc);
        idx = {pc[2:0], ref_bht[h]};
        c = int'(ref_pht[idx]);
        c = tk ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
        e = '0;
        e.pa = idx;
        e.pd = 2'(c);
        e.ba = h;
        e.bd = {ref_bht[h][2:0], tk};
        sb_q.push_back(e);
        ref_pht[idx] = 2'(c);
        ref_bht[h] = e.bd;
    endfunction

    // Monitor: predictions and table-update writes after init
    always @(negedge clk) begin
        ev_t e;
        if (resetn) begin
            if (pred_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pred", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("pred_kind", 1, e.is_pred);
                    check("pred_taken", pred_taken, e.taken);
                end
            end
            if (init_done && (pht_we || bht_we)) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("wr_kind", 0, e.is_pred);
                    check("wr_both_we", {pht_we, bht_we}, 2'b11);
                    check("wr_pht_addr", pht_addr, e.pa);
                    check("wr_pht_wdata", pht_wdata, e.pd);
                    check("wr_bht_addr", bht_addr, e.ba);
                    check("wr_bht_wdata", bht_wdata, e.bd);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (entered and left at a negedge)
    // ------------------------------------------------------------------
    task automatic reset_checks();
        check("rst_lookup_ready", lookup_ready, 0);
        check("rst_pred_valid", pred_valid, 0);
        check("rst_pred_taken", pred_taken, 0);
        check("rst_init_done", init_done, 0);
        check("rst_upd_ready", upd_ready, 0);
        check("rst_we", {pht_we, bht_we}, 0);
        check("rst_addr", {pht_addr, bht_addr}, 0);
        check("rst_wdata", {pht_wdata, bht_wdata}, 0);
    endtask

    task automatic sweep_check(input logic exp_rdy_idle);
        int n_pht = 0, n_bht = 0, bad = 0, bad_rdy = 0, n_pred = 0;
        int last_w = 0, done_cyc = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (init_done) begin
                done_cyc = cyc;
                break;
            end
            if (lookup_ready) bad_rdy++;
            if (pred_valid) n_pred++;
            if (pht_we) begin
                if (pht_addr != 7'(n_pht) || pht_wdata != 2'b01) bad++;
                n_pht++;
                last_w = cyc;
            end
            if (bht_we) begin
                if (bht_addr != 4'(n_bht) || bht_wdata != 4'h0) bad++;
                n_bht++;
            end
        end
        check("sweep_init_done", init_done, 1);
        check("sweep_pht_pulses", n_pht, 128);
        check("sweep_bht_pulses", n_bht, 16);
        check("sweep_addr_data_errs", bad, 0);
        check("sweep_lookup_ready_high", bad_rdy, 0);
        check("sweep_pred_pulses", n_pred, 0);
        check("sweep_done_after_127", done_cyc - last_w, 1);
        check("sweep_first_idle_ready", lookup_ready, exp_rdy_idle);
    endtask

    task automatic push_upd(input logic [31:0] pc, input logic tk, input logic do_model);
        upd_pc = pc;
        upd_taken = tk;
        upd_valid = 1'b1;
        if (do_model) model_update(pc, tk);
        for (int i = 0; i < 200 && !upd_ready; i++) @(negedge clk);
        if (!upd_ready) check("push_timeout", 0, 1);
        else @(posedge clk);
        #1 upd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_lookup(input logic [31:0] pc, input logic [6:0] exp_pht);
        logic acc = 1'b0;
        int lat;
        lookup_pc = pc;
        lookup_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (lookup_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("lk_accept", acc, 1);
        if (acc) begin
            @(posedge clk);
            #1 lookup_valid = 1'b0;
            @(negedge clk);
            check("lk_bht_addr", bht_addr, ref_hash(pc));
            @(negedge clk);
            check("lk_pht_addr", pht_addr, exp_pht);
            lat = 2;
            while (!pred_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check("lk_latency", lat, 4);
        end else begin
            lookup_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 600 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain", sb_q.size(), 0);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [6:0] e;
        int n_pv;
        resetn = 1'b0;
        lookup_valid = 1'b0;
        lookup_pc = '0;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_taken = 1'b0;
        model_reset();

        // Reset values and the full init sweep
        repeat (3) @(negedge clk);
        reset_checks();
        resetn = 1'b1;
        sweep_check(1'b1);

        // Fresh-table lookup, two taken updates, then lookups that see them
        e = model_lookup(32'h0000_0010);
        do_lookup(32'h0000_0010, e);
        push_upd(32'h0000_0010, 1'b1, 1'b1);
        push_upd(32'h0000_0010, 1'b1, 1'b1);
        wait_drain();
        e = model_lookup(32'h0000_0010);
        do_lookup(32'h0000_0010, e);
        e = model_lookup(32'h0000_0000);
        do_lookup(32'h0000_0000, e);

        // Saturation on pc 0: history shifts until the same counter is hit repeatedly
        for (int i = 0; i < 8; i++) push_upd(32'h0000_0000, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) push_upd(32'h0000_0000, 1'b0, 1'b1);
        wait_drain();
        e = model_lookup(32'h0000_0000);
        do_lookup(32'h0000_0000, e);
        e = model_lookup(32'h1234_5677);
        do_lookup(32'h1234_5677, e);
        wait_drain();

        // In-flight lookup plus two queued updates, reset lands in LK_PHT
        for (int i = 0; i < 20 && !lookup_ready; i++) @(negedge clk);
        check("pre_reset_ready", lookup_ready, 1);
        lookup_pc = 32'h0000_0010;
        lookup_valid = 1'b1;
        upd_pc = 32'h0000_0055;
        upd_taken = 1'b1;
        upd_valid = 1'b1;
        @(posedge clk);
        #1 lookup_valid = 1'b0;
        upd_pc = 32'h0000_0066;
        @(posedge clk);
        #1 upd_valid = 1'b0;
        resetn = 1'b0;
        model_reset();
        #1 reset_checks();
        n_pv = 0;
        repeat (3) begin
            @(negedge clk);
            if (pred_valid) n_pv++;
        end
        check("mid_reset_pred", n_pv, 0);
        resetn = 1'b1;

        // Re-init with a full FIFO built during INIT; the full FIFO must be
        // served once before the waiting lookup
        fork
            sweep_check(1'b0);
            begin
                push_upd(32'h0000_0010, 1'b1, 1'b0);
                push_upd(32'h0000_0010, 1'b1, 1'b0);
                push_upd(32'h0000_0023, 1'b0, 1'b0);
                push_upd(32'h0000_0010, 1'b1, 1'b0);
                check("upd_ready_full", upd_ready, 0);
                model_update(32'h0000_0010, 1'b1);
                e = model_lookup(32'h0000_0010);
                model_update(32'h0000_0010, 1'b1);
                model_update(32'h0000_0023, 1'b0);
                model_update(32'h0000_0010, 1'b1);
                do_lookup(32'h0000_0010, e);
            end
        join
        wait_drain();
        repeat (10) @(negedge clk);
        check("sb_leftover", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
